// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcode map and state encodings for the fetch stage and its
// neighbours.
package fetch_unit_pkg;

   localparam int unsigned WORD_WIDTH = 16;
   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned NIB_WIDTH  = 4;
   localparam int unsigned IMM_WIDTH  = 8;
   localparam int unsigned RET_WIDTH  = 16;

   localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;

   // Opcodes 0-7 are ALU operations.
   localparam logic [NIB_WIDTH-1:0] OP_LOAD   = 4'd8;
   localparam logic [NIB_WIDTH-1:0] OP_STORE  = 4'd9;
   localparam logic [NIB_WIDTH-1:0] OP_LOADLO = 4'd10;
   localparam logic [NIB_WIDTH-1:0] OP_LOADHI = 4'd11;
   localparam logic [NIB_WIDTH-1:0] OP_IN     = 4'd12;
   localparam logic [NIB_WIDTH-1:0] OP_OUT    = 4'd13;
   localparam logic [NIB_WIDTH-1:0] OP_JMP    = 4'd14;
   localparam logic [NIB_WIDTH-1:0] OP_BR     = 4'd15;

   // Sequencer states of the control block.
   typedef enum logic [1:0] {
      STATE_FETCH   = 2'd0,
      STATE_REGLOAD = 2'd1,
      STATE_EXECUTE = 2'd2,
      STATE_NEXT    = 2'd3
   } ctrl_state_e;

   // Fetch-side instruction tracker.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } trk_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
module fetch_unit_pc_next
   import fetch_unit_pkg::*;
(
   input  logic [NIB_WIDTH-1:0]  opcode,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [IMM_WIDTH-1:0]  imm8,
   input  logic [WORD_WIDTH-1:0] jump_reg,
   input  logic                  br_cond,
   output logic [ADDR_WIDTH-1:0] pc_nxt_c
);

   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] imm_sext;

   assign pc_inc   = pc + ADDR_WIDTH'(1);
   assign imm_sext = {{(ADDR_WIDTH-IMM_WIDTH){imm8[IMM_WIDTH-1]}}, imm8};

   // Additions are truncated to ADDR_WIDTH, so branches wrap both ways.
   always_comb begin
      pc_nxt_c = pc_inc;
      if (opcode == OP_JMP) begin
         pc_nxt_c = jump_reg[ADDR_WIDTH-1:0];
      end else if (opcode == OP_BR && br_cond) begin
         pc_nxt_c = pc_inc + imm_sext;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: holds the instruction register, decodes its
// fields, advances pc on retire and flags sequencing protocol errors.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  do_fetch,
   input  logic                  do_next,
   input  logic [WORD_WIDTH-1:0] imem_data,
   input  logic [WORD_WIDTH-1:0] jump_reg,
   input  logic                  br_cond,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_rd,
   output logic [NIB_WIDTH-1:0]  opcode,
   output logic                  isaluop,
   output logic [NIB_WIDTH-1:0]  rd,
   output logic [NIB_WIDTH-1:0]  ra,
   output logic [NIB_WIDTH-1:0]  rb,
   output logic [IMM_WIDTH-1:0]  imm8,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [RET_WIDTH-1:0]  retired,
   output logic                  seq_err
);

   trk_state_e            state_q, state_d;
   logic [WORD_WIDTH-1:0] ir_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [RET_WIDTH-1:0]  retired_q;
   logic                  seq_err_q;
   logic                  ir_ld, retire, err_set;
   logic [ADDR_WIDTH-1:0] pc_nxt;

   fetch_unit_pc_next u_pc_next (
      .opcode   (ir_q[15:12]),
      .pc       (pc_q),
      .imm8     (ir_q[7:0]),
      .jump_reg (jump_reg),
      .br_cond  (br_cond),
      .pc_nxt_c (pc_nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Tracker next state and register-update strobes; simultaneous strobes only flag.
   always_comb begin
      state_d = state_q;
      ir_ld   = 1'b0;
      retire  = 1'b0;
      err_set = 1'b0;
      if (do_fetch && do_next) begin
         err_set = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (do_fetch) begin
                  ir_ld   = 1'b1;
                  state_d = S_HELD;
               end else if (do_next) begin
                  err_set = 1'b1;
               end
            end
            S_HELD: begin
               if (do_fetch) begin
                  ir_ld   = 1'b1;
                  err_set = 1'b1;
               end else if (do_next) begin
                  retire  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_q      <= '0;
         pc_q      <= RESET_PC;
         retired_q <= '0;
         seq_err_q <= 1'b0;
      end else begin
         if (ir_ld)   ir_q <= imem_data;
         if (retire) begin
            pc_q      <= pc_nxt;
            retired_q <= retired_q + RET_WIDTH'(1);
         end
         if (err_set) seq_err_q <= 1'b1;
      end
   end

   assign imem_addr = pc_q;
   assign imem_rd   = do_fetch;
   assign opcode    = ir_q[15:12];
   assign isaluop   = ~ir_q[15];
   assign rd        = ir_q[11:8];
   assign ra        = ir_q[7:4];
   assign rb        = ir_q[3:0];
   assign imm8      = ir_q[7:0];
   assign pc        = pc_q;
   assign retired   = retired_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        do_fetch, do_next, br_cond;
   logic [15:0] imem_data, jump_reg;
   logic [15:0] imem_addr, pc, retired;
   logic        imem_rd, isaluop, seq_err;
   logic [3:0]  opcode, rd, ra, rb;
   logic [7:0]  imm8;

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .do_fetch  (do_fetch),
      .do_next   (do_next),
      .imem_data (imem_data),
      .jump_reg  (jump_reg),
      .br_cond   (br_cond),
      .imem_addr (imem_addr),
      .imem_rd   (imem_rd),
      .opcode    (opcode),
      .isaluop   (isaluop),
      .rd        (rd),
      .ra        (ra),
      .rb        (rb),
      .imm8      (imm8),
      .pc        (pc),
      .retired   (retired),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] w);
      do_fetch  = 1'b1;
      imem_data = w;
      tick();
      do_fetch  = 1'b0;
   endtask

   task automatic next(input logic [15:0] jr, input logic bc);
      do_next  = 1'b1;
      jump_reg = jr;
      br_cond  = bc;
      tick();
      do_next  = 1'b0;
      br_cond  = 1'b0;
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; do_fetch = 1'b0; do_next = 1'b0; br_cond = 1'b0;
      imem_data = 16'h0; jump_reg = 16'h0;
      #1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_opcode", 16'(opcode), 16'h0);
      chk("rst_isaluop", 16'(isaluop), 16'h1);
      chk("rst_fields", {rd, ra, rb, 4'h0}, 16'h0000);
      chk("rst_retired", retired, 16'h0000);
      chk("rst_seq_err", 16'(seq_err), 16'h0);
      do_fetch = 1'b1;
      #1;
      chk("rst_imem_rd", 16'(imem_rd), 16'h1);
      do_fetch = 1'b0;
      #1;
      chk("rst_imem_rd_low", 16'(imem_rd), 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Basic fetch / retire
      do_fetch = 1'b1; imem_data = 16'h3421;
      #1;
      chk("fetch_imem_addr", imem_addr, 16'h0000);
      chk("fetch_imem_rd", 16'(imem_rd), 16'h1);
      tick();
      do_fetch = 1'b0;
      chk("alu_opcode", 16'(opcode), 16'h3);
      chk("alu_isaluop", 16'(isaluop), 16'h1);
      chk("alu_fields", {4'h0, rd, ra, rb}, 16'h0421);
      chk("alu_imm8", 16'(imm8), 16'h0021);
      chk("alu_pc_held", pc, 16'h0000);
      next(16'hBEEF, 1'b0);
      chk("alu_pc", pc, 16'h0001);
      chk("alu_retired", retired, 16'h0001);
      chk("alu_seq_err", 16'(seq_err), 16'h0);

      // Jump
      fetch(16'hE050);
      chk("jmp_opcode", 16'(opcode), 16'hE);
      chk("jmp_isaluop", 16'(isaluop), 16'h0);
      next(16'h1234, 1'b1);
      chk("jmp_pc", pc, 16'h1234);
      chk("jmp_retired", retired, 16'h0002);

      // Branch taken backward across zero
      fetch(16'hE000); next(16'h0002, 1'b0);
      fetch(16'hF0FC); next(16'h0000, 1'b1);
      chk("br_back_pc", pc, 16'hFFFF);
      chk("br_back_addr", imem_addr, 16'hFFFF);
      chk("br_back_retired", retired, 16'h0004);

      // Sequential wrap
      fetch(16'h8000); next(16'h0000, 1'b0);
      chk("seq_wrap_pc", pc, 16'h0000);

      // Branch not taken
      fetch(16'hE000); next(16'h0002, 1'b0);
      fetch(16'hF0FC); next(16'h0000, 1'b0);
      chk("br_nt_pc", pc, 16'h0003);
      chk("br_nt_retired", retired, 16'h0007);

      // Branch taken forward, then forward wrap
      fetch(16'hF005); next(16'h0000, 1'b1);
      chk("br_fwd_pc", pc, 16'h0009);
      fetch(16'hE000); next(16'hFFF0, 1'b0);
      fetch(16'hF07F); next(16'h0000, 1'b1);
      chk("br_fwd_wrap_pc", pc, 16'h0070);

      // br_cond ignored on non-branch opcodes
      fetch(16'h1234); next(16'h5555, 1'b1);
      chk("alu_brcond_pc", pc, 16'h0071);
      chk("alu_brcond_retired", retired, 16'h000B);
      chk("no_err_yet", 16'(seq_err), 16'h0);

      // do_next with no fetch
      next(16'h4444, 1'b0);
      chk("idle_next_pc", pc, 16'h0071);
      chk("idle_next_retired", retired, 16'h000B);
      chk("idle_next_err", 16'(seq_err), 16'h1);

      // Simultaneous strobes while idle change nothing but the flag
      do_reset();
      chk("rst2_err", 16'(seq_err), 16'h0);
      do_fetch = 1'b1; do_next = 1'b1; imem_data = 16'hABCD;
      tick();
      do_fetch = 1'b0; do_next = 1'b0;
      chk("both_idle_err", 16'(seq_err), 16'h1);
      chk("both_idle_opcode", 16'(opcode), 16'h0);
      chk("both_idle_pc", pc, 16'h0000);
      next(16'h0000, 1'b0);
      chk("both_idle_still_idle", pc, 16'h0000);
      chk("both_idle_retired", retired, 16'h0000);

      // Simultaneous strobes while held
      fetch(16'h3421);
      do_fetch = 1'b1; do_next = 1'b1; imem_data = 16'hFFFF;
      tick();
      do_fetch = 1'b0; do_next = 1'b0;
      chk("both_held_opcode", 16'(opcode), 16'h3);
      chk("both_held_pc", pc, 16'h0000);
      next(16'h0000, 1'b0);
      chk("both_held_next_pc", pc, 16'h0001);
      chk("both_held_retired", retired, 16'h0001);

      // Refetch while held
      do_reset();
      fetch(16'h1111);
      fetch(16'h2222);
      chk("refetch_opcode", 16'(opcode), 16'h2);
      chk("refetch_err", 16'(seq_err), 16'h1);
      chk("refetch_pc", pc, 16'h0000);
      next(16'h0000, 1'b0);
      chk("refetch_next_pc", pc, 16'h0001);

      // Async reset mid-instruction (during REGLOAD)
      fetch(16'hE321);
      #2 reset_n = 1'b0;
      #1;
      chk("async_pc", pc, 16'h0000);
      chk("async_opcode", 16'(opcode), 16'h0);
      chk("async_fields", {4'h0, rd, ra, rb}, 16'h0000);
      chk("async_retired", retired, 16'h0000);
      chk("async_err", 16'(seq_err), 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      next(16'h7777, 1'b0);
      chk("async_idle_pc", pc, 16'h0000);
      fetch(16'h0123); next(16'h0000, 1'b0);
      chk("async_after_pc", pc, 16'h0001);
      chk("async_after_retired", retired, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
